seq_detect_param: RTL
=====================

Name: seq_detect_param

Overview:
Parametrised serial bit-sequence detector, Mealy style. It generalises the fixed 4-bit "1001" non-overlapping detector to any pattern length and value, with overlap or non-overlap selectable per instance. It also adds a qualifying enable, a registered match flag and a saturating match counter. It sits on a 1-bit serial input stream in the FSM library and serves as the drop-in next generation of the fixed detectors.

Parameters:
SEQ_LEN, 4, pattern length in bits (2..32).
PATTERN, 4'b1001, target sequence, MSB = first bit received, width SEQ_LEN.
OVERLAP, 0, 0 = non-overlapping (history cleared after match), 1 = overlapping (history kept).
CNT_W, 8, width of match counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active low.
signal  input  1  serial data bit, sampled on rising clk when en=1.
en  input  1  bit-valid qualifier; en=0 means no bit this cycle, all state held.
out  output  1  Mealy match: combinational, high in the cycle whose current signal completes PATTERN.
out_q  output  1  out registered one cycle later.
match_cnt  output  CNT_W  count of matches since reset, saturating.
cnt_sat  output  1  high when match_cnt is all ones.

Behaviour:
- Reset (rst=0, async): history=0, fill=0, out_q=0, match_cnt=0, cnt_sat=0. out is low during reset regardless of inputs.
- State:
  - hist[SEQ_LEN-2:0]: last received bits.
  - fill: number of valid history bits, 0..SEQ_LEN-1, saturating at SEQ_LEN-1.
- Match (combinational): out = en & (fill == SEQ_LEN-1) & ({hist, signal} == PATTERN).
- On a rising clk with en=1:
  - hist shifts left and takes signal at bit 0.
  - fill increments, saturating at SEQ_LEN-1.
  - If out=1 and OVERLAP=0: fill clears to 0 and hist clears to 0. The next match needs SEQ_LEN fresh bits.
  - If out=1 and OVERLAP=1: normal shift; fill stays at SEQ_LEN-1.
- en=0: hist, fill and match_cnt hold; out=0.
- out_q <= out on every clock, independent of en.
- Counter: match_cnt increments when out=1 at a rising edge. At all ones it holds; no wrap.
- cnt_sat is registered and is high exactly when match_cnt is all ones.
- Reset mid-sequence discards partial history. After rst is released, the first match needs a full SEQ_LEN bits.
- Patterns with self-overlap (e.g. 1111) are handled correctly in both modes, because detection is a full-window compare rather than fixed state encoding.
- out is combinational on signal. Consumers in the same clock domain sample it at the rising edge that consumes the completing bit.

Optional Feature:
Macro SEQ_DETECT_PATTERN_LOAD_EN.
- With it:
  - Extra ports pat_load (input, 1) and pat_in (input, SEQ_LEN).
  - pat_load=1 at a rising edge writes pat_in into a pattern register and clears hist, fill, out_q and match_cnt.
  - During that cycle out is forced to 0.
  - The pattern register resets to PATTERN, and matching uses the register instead of the parameter.
- Without it: no extra ports; the pattern is the constant PATTERN.

Decomposition:
- Package seq_detect_pkg holds:
  - the mode constants OVL_NONE = 0 and OVL_ALLOW = 1;
  - the maximum SEQ_LEN limit (32);
  - a function clog2 for sizing fill.
- One natural sub-module: seq_match_cnt, a saturating CNT_W counter with inc input, count output and sat flag. It is reused by other detectors.

Test Plan:
1. Default params, OVERLAP=0, en=1, after reset drive 1,0,0,1,0,0,1 -> out high only on bit 4; match_cnt=1. Bit 7 does not match because history was cleared.
2. Same stream, OVERLAP=1 -> out high on bits 4 and 7; match_cnt=2; out_q follows out one cycle later.
3. Stream 1,0,0 then en=0 for 3 cycles (signal toggling), then en=1 with bit 1 -> out stays low while en=0; out goes high on the completing bit; match_cnt=1.
4. Drive 1,0,0, pulse rst low mid-cycle, release, then drive 1 -> no match. Outputs are 0 immediately on rst assertion; a subsequent 1,0,0,1 gives match_cnt=1.
5. CNT_W=2, OVERLAP=1, PATTERN=2'b11, SEQ_LEN=2, drive six 1s -> five matches; match_cnt saturates at 3; cnt_sat=1 from the third match onward.
6. With SEQ_DETECT_PATTERN_LOAD_EN: load pat_in=4'b0110, then drive 0,1,1,0 -> match on bit 4. A following 1,0,0,1 gives no match; match_cnt=1.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared constants and helpers for the serial sequence detector family.
//   OVL_NONE / OVL_ALLOW : values for a detector's OVERLAP parameter
//   SEQ_LEN_MAX          : longest pattern a detector instance supports
//   clog2()              : bit width needed to hold the values 0..value-1
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    localparam int OVL_NONE    = 0;   // history cleared after every match
    localparam int OVL_ALLOW   = 1;   // history kept, matches may share bits
    localparam int SEQ_LEN_MAX = 32;

    // Smallest r with 2**r >= value; returns at least 1 so a width is never 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// -----------------------------------------------------------------------------
// seq_match_cnt
// Saturating event counter shared by the sequence detectors.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   inc_i    : count one event at this edge (ignored once saturated)
//   clr_i    : synchronous clear, takes priority over inc_i
//   count_o  : events counted since reset / last clear, saturating
//   sat_o    : registered flag, high exactly when count_o is all ones
// -----------------------------------------------------------------------------
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
        // Derived from the next count so the flag lands in the same cycle
        // as the value it describes.
        sat_d = &count_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Parametrised Mealy detector for a SEQ_LEN-bit pattern on a 1-bit serial
// stream. Detection compares the full window {history, current bit} against
// the pattern, so self-overlapping patterns need no special handling.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   signal     : serial data bit, consumed on a rising edge when en=1
//   en         : bit-valid qualifier; en=0 holds all detector state
//   out        : combinational match for the bit currently on signal
//   out_q      : out delayed by one clock (updated every clock)
//   match_cnt  : saturating count of matches since reset
//   cnt_sat    : high when match_cnt is all ones
// Optional build macro SEQ_DETECT_PATTERN_LOAD_EN adds:
//   pat_load   : load pat_in as the new pattern and restart detection
//   pat_in     : replacement pattern, MSB is the first bit received
// -----------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1001,
    parameter int                 OVERLAP = OVL_NONE,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal,
    input  logic             en,
    output logic             out,
    output logic             out_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
`ifdef SEQ_DETECT_PATTERN_LOAD_EN
    ,
    input  logic               pat_load,
    input  logic [SEQ_LEN-1:0] pat_in
`endif
);

    localparam int HIST_W = SEQ_LEN - 1;
    localparam int FILL_W = clog2(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN - 1);

    logic [HIST_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [SEQ_LEN-1:0] pattern;
    logic [SEQ_LEN-1:0] window;
    logic               load;
    logic               match;

`ifdef SEQ_DETECT_PATTERN_LOAD_EN
    logic [SEQ_LEN-1:0] pat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PATTERN;
        end else if (pat_load) begin
            pat_q <= pat_in;
        end
    end

    assign pattern = pat_q;
    assign load    = pat_load;
`else
    assign pattern = PATTERN;
    assign load    = 1'b0;
`endif

    // The current bit completes the window; it is only a match once the
    // history holds SEQ_LEN-1 bits received since the last clear.
    assign window = {hist_q, signal};
    assign match  = rst & en & ~load & (fill_q == FILL_FULL) & (window == pattern);
    assign out    = match;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            if (match && (OVERLAP == OVL_NONE)) begin
                // Non-overlapping: the next match needs SEQ_LEN fresh bits.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[HIST_W-1:0];
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end
    end

    // out_q needs no explicit clear on a pattern load: match is already
    // forced low during that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= match;
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (match),
        .clr_i   (load),
        .count_o (match_cnt),
        .sat_o   (cnt_sat)
    );

endmodule
